hps_pio_slave: RTL

HPS_PIO_SLAVE -- requirements
Module: hps_pio_slave

---
 rtl/hps_pio_slave_if.sv | 20 ++
 rtl/hps_pio_slave.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hps_pio_slave_if.sv
// Avalon-MM slave bus bundle for the HPS PIO block: word address, strobes,
// write data, and registered read data with its valid qualifier.
interface hps_pio_slave_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/hps_pio_slave.sv
// HPS PIO slave: LED output register, debounced switch input with per-bit
// edge capture, maskable level interrupt, fixed one-cycle read latency.
module hps_pio_slave #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    hps_pio_slave_if.slave        avs,
    output logic [DATA_WIDTH-1:0] leds_export,
    input  logic [DATA_WIDTH-1:0] switches_export,
    output logic                  irq
);
    localparam int CLOG = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW   = (CLOG < 1) ? 1 : CLOG;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] A_LED    = 3'd0;
    localparam logic [2:0] A_SWITCH = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic [DATA_WIDTH-1:0] led_q, led_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] edge_q, edge_d;
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q;
    logic [DATA_WIDTH-1:0] db_q, db_d;
    logic [CW-1:0]         cnt_q [DATA_WIDTH];
    logic [CW-1:0]         cnt_d [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] set_edge, clr_edge;
    logic                  irq_q, irq_d;
    logic [31:0]           rdata_q, rdata_d, rd_word;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_wdata;

    // A simultaneous read wins over the write, so the write is dropped.
    assign wr_en = avs.avs_write & ~avs.avs_read;
    assign wdata = avs.avs_writedata[DATA_WIDTH-1:0];
    // Upper write-data bits have no storage behind them.
    assign unused_wdata = ^avs.avs_writedata;

    // Per-bit debounce: count while the synchronized bit disagrees with the
    // debounced bit, commit after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        db_d     = db_q;
        set_edge = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]     = sync2_q[i];
                    set_edge[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Register writes; an edge set in the same cycle as its clear is kept.
    always_comb begin
        led_d    = led_q;
        mask_d   = mask_q;
        clr_edge = '0;
        if (wr_en) begin
            case (avs.avs_address)
                A_LED:   led_d    = wdata;
                A_MASK:  mask_d   = wdata;
                A_EDGE:  clr_edge = wdata;
                default: ;
            endcase
        end
        edge_d = (edge_q & ~clr_edge) | set_edge;
        irq_d  = |(edge_q & mask_q);
    end

    // Read mux; readdata is held at zero whenever no read completes.
    always_comb begin
        rd_word = '0;
        case (avs.avs_address)
            A_LED:    rd_word[DATA_WIDTH-1:0] = led_q;
            A_SWITCH: rd_word[DATA_WIDTH-1:0] = db_q;
            A_MASK:   rd_word[DATA_WIDTH-1:0] = mask_q;
            A_EDGE:   rd_word[DATA_WIDTH-1:0] = edge_q;
            A_STATUS: rd_word[0]              = irq_q;
            default:  rd_word = '0;
        endcase
        rvalid_d = avs.avs_read;
        rdata_d  = avs.avs_read ? rd_word : 32'd0;
    end

    // State registers, including the 2-flop switch synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            led_q    <= led_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            sync1_q  <= switches_export;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;
    assign leds_export           = led_q;
    assign irq                   = irq_q;
endmodule
